// File: rtl/window_shift_buffer.sv
// window_shift_buffer
// Collects feature columns from one of two ping-pong line sources into a
// TN x K x K window.  K, stride and window count are set per job at start.
// The first window of a job needs K columns.  Each later window reuses the
// older columns and needs only `stride` new ones.  Handshakes run on both
// the column input and the window output.
module window_shift_buffer #(
  parameter int unsigned TN            = 4,
  parameter int unsigned KMAX          = 5,
  parameter int unsigned FEATURE_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [3:0]                             kernel_size,
  input  logic [2:0]                             stride,
  input  logic [7:0]                             win_count,
  input  logic                                   in_select,
  input  logic                                   col_valid,
  output logic                                   col_ready,
  input  logic [TN*KMAX*FEATURE_WIDTH-1:0]       dia_0,
  input  logic [TN*KMAX*FEATURE_WIDTH-1:0]       dia_1,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [TN*KMAX*KMAX*FEATURE_WIDTH-1:0]  doa,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int unsigned FW = FEATURE_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [3:0]  k_reg;
  logic [2:0]  stride_reg;
  logic [3:0]  need;
  logic [7:0]  windows_left;

  // Window storage indexed [channel][slot][row].  Slot 0 holds the newest column.
  logic [FW-1:0] win_mem [TN][KMAX][KMAX];

  logic [TN*KMAX*FW-1:0] col_sel;
  logic                  cfg_bad;
  logic                  col_fire;
  logic                  win_fire;

  // Select the active line source and qualify the handshakes.
  always_comb begin
    col_sel  = in_select ? dia_1 : dia_0;
    col_fire = (state == ST_FILL) && col_valid;
    win_fire = (state == ST_HOLD) && win_ready;
    cfg_bad  = (kernel_size == 4'd0) ||
               (kernel_size > 4'(KMAX)) ||
               (stride == 3'd0) ||
               ({1'b0, stride} > kernel_size) ||
               (win_count == 8'd0);
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    col_ready = (state == ST_FILL);
    win_valid = (state == ST_HOLD);
    busy      = (state != ST_IDLE);
  end

  // Flatten the window storage onto the output bus.
  always_comb begin
    doa = '0;
    for (int unsigned n = 0; n < TN; n++) begin
      for (int unsigned s = 0; s < KMAX; s++) begin
        for (int unsigned r = 0; r < KMAX; r++) begin
          doa[(((n*KMAX)+s)*KMAX+r)*FW +: FW] = win_mem[n][s][r];
        end
      end
    end
  end

  // Job sequencing FSM and its counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      k_reg        <= '0;
      stride_reg   <= '0;
      need         <= '0;
      windows_left <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              k_reg        <= kernel_size;
              stride_reg   <= stride;
              need         <= kernel_size;
              windows_left <= win_count;
              state        <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (col_fire) begin
            if (need != 4'd0) need <= need - 4'd1;
            if (need <= 4'd1) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (win_fire) begin
            if (windows_left != 8'd0) windows_left <= windows_left - 8'd1;
            if (windows_left <= 8'd1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              need  <= {1'b0, stride_reg};
              state <= ST_FILL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Window storage: cleared at job start.  On each accepted column it shifts
  // by one slot, and the new column is loaded into slot 0.  Slots and rows at
  // or beyond K are held at zero, so a smaller K never exposes stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < TN; n++)
        for (int unsigned s = 0; s < KMAX; s++)
          for (int unsigned r = 0; r < KMAX; r++)
            win_mem[n][s][r] <= '0;
    end else if ((state == ST_IDLE) && start && !cfg_bad) begin
      for (int unsigned n = 0; n < TN; n++)
        for (int unsigned s = 0; s < KMAX; s++)
          for (int unsigned r = 0; r < KMAX; r++)
            win_mem[n][s][r] <= '0;
    end else if (col_fire) begin
      for (int unsigned n = 0; n < TN; n++) begin
        for (int unsigned s = 0; s < KMAX; s++) begin
          for (int unsigned r = 0; r < KMAX; r++) begin
            if ((s >= 32'(k_reg)) || (r >= 32'(k_reg)))
              win_mem[n][s][r] <= '0;
            else if (s == 0)
              win_mem[n][s][r] <= col_sel[((n*KMAX)+r)*FW +: FW];
            else
              win_mem[n][s][r] <= win_mem[n][s-1][r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_shift_buffer.sv
// Testbench for window_shift_buffer: directed job sequence with randomized
// column data, source selection and backpressure.  The checks run against a
// column-history reference model.
module tb_window_shift_buffer;

  localparam int TN    = 4;
  localparam int KMAX  = 5;
  localparam int FW    = 16;
  localparam int DIN_W = TN*KMAX*FW;
  localparam int DOA_W = TN*KMAX*KMAX*FW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       kernel_size = '0;
  logic [2:0]       stride = '0;
  logic [7:0]       win_count = '0;
  logic             in_select = 1'b0;
  logic             col_valid = 1'b0;
  logic             col_ready;
  logic [DIN_W-1:0] dia_0 = '0;
  logic [DIN_W-1:0] dia_1 = '0;
  logic             win_valid;
  logic             win_ready = 1'b0;
  logic [DOA_W-1:0] doa;
  logic             busy;
  logic             done;
  logic             err;

  int errors = 0;
  int checks = 0;

  // Every column accepted in the current job, oldest first.
  logic [DIN_W-1:0] hist [$];

  window_shift_buffer #(.TN(TN), .KMAX(KMAX), .FEATURE_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
    .stride(stride), .win_count(win_count), .in_select(in_select),
    .col_valid(col_valid), .col_ready(col_ready), .dia_0(dia_0), .dia_1(dia_1),
    .win_valid(win_valid), .win_ready(win_ready), .doa(doa), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIN_W-1:0] rand_col();
    logic [DIN_W-1:0] v;
    for (int i = 0; i < DIN_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // The window is the K most recent columns: slot s is the column accepted
  // s steps before the newest.  Rows and slots at or beyond K read as zero.
  function automatic logic [DOA_W-1:0] model_window(int k);
    logic [DOA_W-1:0] w;
    logic [DIN_W-1:0] c;
    int h;
    w = '0;
    h = hist.size();
    for (int s = 0; s < k && s < h; s++) begin
      c = hist[h-1-s];
      for (int n = 0; n < TN; n++)
        for (int r = 0; r < k; r++)
          w[(((n*KMAX)+s)*KMAX+r)*FW +: FW] = c[((n*KMAX)+r)*FW +: FW];
    end
    return w;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_col_ready"}, 80'(col_ready), 80'd0);
    check({tag, "_win_valid"}, 80'(win_valid), 80'd0);
    check({tag, "_busy"},      80'(busy),      80'd0);
    check({tag, "_done"},      80'(done),      80'd0);
    check({tag, "_err"},       80'(err),       80'd0);
    check({tag, "_doa_zero"},  80'(doa == '0), 80'd1);
  endtask

  task automatic check_window(input int k, input int w);
    logic [DOA_W-1:0] e;
    e = model_window(k);
    for (int n = 0; n < TN; n++)
      for (int s = 0; s < KMAX; s++)
        check($sformatf("win%0d_k%0d_n%0d_s%0d", w, k, n, s),
              80'(doa[((n*KMAX)+s)*KMAX*FW +: KMAX*FW]),
              80'(e[((n*KMAX)+s)*KMAX*FW +: KMAX*FW]));
  endtask

  // Runs one full job from start through its done pulse.
  task automatic run_job(input int k, input int st, input int wc);
    int need, got, cyc, hold;
    logic [DOA_W-1:0] held;
    @(negedge clk);
    kernel_size = 4'(k); stride = 3'(st); win_count = 8'(wc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hist.delete();
    check("start_busy", 80'(busy), 80'd1);
    check("start_err", 80'(err), 80'd0);
    for (int w = 0; w < wc; w++) begin
      check($sformatf("fill%0d_col_ready", w), 80'(col_ready), 80'd1);
      need = (w == 0) ? k : st;
      got = 0;
      cyc = 0;
      while (got < need && cyc < 200) begin
        check("fill_win_valid", 80'(win_valid), 80'd0);
        col_valid = ($urandom_range(0, 3) != 0);
        win_ready = $urandom_range(0, 1);
        in_select = $urandom_range(0, 1);
        dia_0 = rand_col();
        dia_1 = rand_col();
        if (col_valid && col_ready) begin
          hist.push_back(in_select ? dia_1 : dia_0);
          got++;
        end
        @(negedge clk);
        cyc++;
      end
      col_valid = 1'b0;
      win_ready = 1'b0;
      check("fill_budget", 80'(got), 80'(need));
      check("hold_win_valid", 80'(win_valid), 80'd1);
      check("hold_col_ready", 80'(col_ready), 80'd0);
      check_window(k, w);
      held = doa;
      hold = $urandom_range(0, 4);
      repeat (hold) begin
        col_valid = 1'b1;
        dia_0 = rand_col();
        dia_1 = rand_col();
        @(negedge clk);
        check("stall_win_valid", 80'(win_valid), 80'd1);
        check("stall_col_ready", 80'(col_ready), 80'd0);
        check("stall_doa_stable", 80'(doa === held), 80'd1);
      end
      col_valid = 1'b0;
      win_ready = 1'b1;
      @(negedge clk);
      win_ready = 1'b0;
      if (w == wc - 1) begin
        check("job_done", 80'(done), 80'd1);
        check("job_idle_busy", 80'(busy), 80'd0);
        check("job_idle_win_valid", 80'(win_valid), 80'd0);
      end else begin
        check("next_done", 80'(done), 80'd0);
      end
    end
    @(negedge clk);
    check("done_pulse_end", 80'(done), 80'd0);
    check("idle_col_ready", 80'(col_ready), 80'd0);
  endtask

  task automatic illegal(input int k, input int st, input int wc);
    @(negedge clk);
    kernel_size = 4'(k); stride = 3'(st); win_count = 8'(wc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("illegal_k%0d_s%0d_w%0d_err", k, st, wc), 80'(err), 80'd1);
    check("illegal_busy", 80'(busy), 80'd0);
    check("illegal_col_ready", 80'(col_ready), 80'd0);
    @(negedge clk);
    check("illegal_err_pulse", 80'(err), 80'd0);
    check("illegal_busy_after", 80'(busy), 80'd0);
  endtask

  initial begin
    // Reset held.
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    col_valid = 1'b1;
    repeat (2) @(negedge clk);
    col_valid = 1'b0;
    check_outputs_zero("post_reset");

    // Directed geometries from the job-level scenarios.
    run_job(5, 1, 3);
    run_job(3, 1, 1);
    run_job(5, 2, 2);
    run_job(1, 1, 2);
    run_job(4, 4, 2);

    // Illegal configurations.
    illegal(6, 1, 1);
    illegal(3, 0, 1);
    illegal(3, 4, 1);
    illegal(3, 1, 0);
    illegal(0, 1, 1);

    // Reset in the middle of a fill, after 3 of 5 columns.
    @(negedge clk);
    kernel_size = 4'd5; stride = 3'd1; win_count = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    col_valid = 1'b1;
    dia_0 = rand_col();
    repeat (3) @(negedge clk);
    col_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    run_job(5, 1, 1);

    // Randomized legal jobs.
    for (int j = 0; j < 6; j++) begin
      int k, st, wc;
      k  = $urandom_range(1, KMAX);
      st = $urandom_range(1, k);
      wc = $urandom_range(1, 4);
      run_job(k, st, wc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
